// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe board: cell/result codes, sizes, FSM states.
// Optional turn timeout is enabled with the TURNO_TIMEOUT_EN macro.
package gato_pkg;

    localparam int unsigned ANCHO_CELDA    = 2;
    localparam int unsigned NUM_CELDAS     = 9;
    localparam int unsigned CELDAS_FILA    = 3;
    localparam int unsigned ANCHO_FILA     = ANCHO_CELDA * CELDAS_FILA;
    localparam int unsigned ANCHO_TABLERO  = ANCHO_FILA * 3;
    localparam int unsigned ANCHO_POS      = 4;
    localparam int unsigned ANCHO_CONT     = 4;
    localparam int unsigned ANCHO_TMO      = 26;
    localparam int unsigned CICLOS_TIMEOUT = 50000000;

    // Cell codes; 2'b11 is never written
    localparam logic [ANCHO_CELDA-1:0] VACIA = 2'b00;
    localparam logic [ANCHO_CELDA-1:0] JUG_X = 2'b01;
    localparam logic [ANCHO_CELDA-1:0] JUG_O = 2'b10;

    // Result codes
    localparam logic [1:0] RES_NADA   = 2'b00;
    localparam logic [1:0] RES_X      = 2'b01;
    localparam logic [1:0] RES_O      = 2'b10;
    localparam logic [1:0] RES_EMPATE = 2'b11;

    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        VERIFICA = 3'd1,
        ESCRIBE  = 3'd2,
        EVALUA   = 3'd3,
        FIN      = 3'd4
    } estado_t;

    // Cell code written for a requester (0 = X, 1 = O)
    function automatic logic [ANCHO_CELDA-1:0] codigo_jugador(input logic jug);
        return jug ? JUG_O : JUG_X;
    endfunction

endpackage

// File: rtl/detector_linea.sv
// Combinational three-in-a-row detector over the flat 18-bit board.
// Cell k occupies bits [2k+1:2k]; returns the winning cell code or 00.
module detector_linea
    import gato_pkg::*;
(
    input  logic [ANCHO_TABLERO-1:0] tablero,
    output logic [ANCHO_CELDA-1:0]   ganador_linea
);

    localparam int unsigned NUM_LINEAS = 8;

    // Cell indices of the 3 rows, 3 columns and 2 diagonals
    localparam logic [3:0] LINEAS [NUM_LINEAS][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    logic [ANCHO_CELDA-1:0] celda [NUM_CELDAS];

    // Split the board into cells
    always_comb begin
        for (int i = 0; i < NUM_CELDAS; i++) begin
            celda[i] = tablero[ANCHO_CELDA*i +: ANCHO_CELDA];
        end
    end

    // Report the code of any line holding three equal non-empty cells
    always_comb begin
        ganador_linea = RES_NADA;
        for (int l = 0; l < NUM_LINEAS; l++) begin
            if (celda[LINEAS[l][0]] != VACIA &&
                celda[LINEAS[l][0]] == celda[LINEAS[l][1]] &&
                celda[LINEAS[l][1]] == celda[LINEAS[l][2]]) begin
                ganador_linea = celda[LINEAS[l][0]];
            end
        end
    end

endmodule

// File: rtl/control_turnos.sv
// Turn sequencer and sole writer of the three board row words.
// Checks each move, writes it, then evaluates win/draw.
// Optional macro TURNO_TIMEOUT_EN adds a per-turn forfeit timer.
module control_turnos
    import gato_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  jugada,
    input  logic                  jugador,
    input  logic [ANCHO_POS-1:0]  posicion,
    output logic [ANCHO_FILA-1:0] fila1,
    output logic [ANCHO_FILA-1:0] fila2,
    output logic [ANCHO_FILA-1:0] fila3,
    output logic                  turno,
    output logic                  error,
    output logic [1:0]            ganador,
    output logic                  fin_juego
);

    estado_t                    estado;
    logic                       jug_q;
    logic [ANCHO_POS-1:0]       pos_q;
    logic [ANCHO_CONT-1:0]      contador;
    logic [ANCHO_TABLERO-1:0]   tablero;
    logic [ANCHO_TABLERO-1:0]   tablero_nuevo;
    logic [ANCHO_CELDA-1:0]     celda_obj;
    logic [ANCHO_CELDA-1:0]     ganador_linea;
    logic                       legal;
`ifdef TURNO_TIMEOUT_EN
    logic [ANCHO_TMO-1:0]       cnt_tmo;
`endif

    assign tablero = {fila3, fila2, fila1};

    // Target cell lookup and the board with the latched move applied
    always_comb begin
        celda_obj     = 2'b11;
        tablero_nuevo = tablero;
        for (int i = 0; i < NUM_CELDAS; i++) begin
            if (pos_q == ANCHO_POS'(i)) begin
                celda_obj = tablero[ANCHO_CELDA*i +: ANCHO_CELDA];
                tablero_nuevo[ANCHO_CELDA*i +: ANCHO_CELDA] = codigo_jugador(jug_q);
            end
        end
    end

    // Move is legal when in range, on turn and onto an empty cell
    always_comb begin
        legal = (pos_q < ANCHO_POS'(NUM_CELDAS)) && (jug_q == turno) && (celda_obj == VACIA);
    end

    detector_linea u_detector (
        .tablero       (tablero),
        .ganador_linea (ganador_linea)
    );

    // Game FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= ESPERA;
            jug_q     <= 1'b0;
            pos_q     <= '0;
            contador  <= '0;
            fila1     <= '0;
            fila2     <= '0;
            fila3     <= '0;
            turno     <= 1'b0;
            error     <= 1'b0;
            ganador   <= RES_NADA;
            fin_juego <= 1'b0;
`ifdef TURNO_TIMEOUT_EN
            cnt_tmo   <= '0;
`endif
        end else begin
            error <= 1'b0;
`ifdef TURNO_TIMEOUT_EN
            cnt_tmo <= '0;
`endif
            case (estado)
                ESPERA: begin
                    if (jugada) begin
                        jug_q  <= jugador;
                        pos_q  <= posicion;
                        estado <= VERIFICA;
                    end
`ifdef TURNO_TIMEOUT_EN
                    else if (cnt_tmo == ANCHO_TMO'(CICLOS_TIMEOUT - 1)) begin
                        turno <= ~turno;
                        error <= 1'b1;
                    end else begin
                        cnt_tmo <= cnt_tmo + 1'b1;
                    end
`endif
                end
                VERIFICA: begin
                    if (legal) begin
                        estado <= ESCRIBE;
                    end else begin
                        error  <= 1'b1;
                        estado <= ESPERA;
                    end
                end
                ESCRIBE: begin
                    {fila3, fila2, fila1} <= tablero_nuevo;
                    if (contador != ANCHO_CONT'(NUM_CELDAS)) begin
                        contador <= contador + 1'b1;
                    end
                    turno  <= ~turno;
                    estado <= EVALUA;
                end
                EVALUA: begin
                    // A line wins even on the ninth move
                    if (ganador_linea != RES_NADA) begin
                        ganador   <= ganador_linea;
                        fin_juego <= 1'b1;
                        estado    <= FIN;
                    end else if (contador == ANCHO_CONT'(NUM_CELDAS)) begin
                        ganador   <= RES_EMPATE;
                        fin_juego <= 1'b1;
                        estado    <= FIN;
                    end else begin
                        estado <= ESPERA;
                    end
                end
                FIN: begin
                    estado <= FIN;
                end
                default: begin
                    estado <= ESPERA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_turnos.sv
// Self-checking bench for control_turnos: directed games plus random moves,
// compared every cycle against a transaction-level game model.
module tb_control_turnos;

    logic       clk = 1'b0;
    logic       reset;
    logic       jugada;
    logic       jugador;
    logic [3:0] posicion;
    logic [5:0] fila1, fila2, fila3;
    logic       turno;
    logic       error;
    logic [1:0] ganador;
    logic       fin_juego;

    always #5 clk = ~clk;

    control_turnos dut (
        .clk       (clk),
        .reset     (reset),
        .jugada    (jugada),
        .jugador   (jugador),
        .posicion  (posicion),
        .fila1     (fila1),
        .fila2     (fila2),
        .fila3     (fila3),
        .turno     (turno),
        .error     (error),
        .ganador   (ganador),
        .fin_juego (fin_juego)
    );

    int checks   = 0;
    int failures = 0;

    // Game model: board, turn, result, plus the edges at which pending effects appear
    localparam int NUNCA = 32'h3fffffff;
    int  cells [9];
    bit  m_turn;
    bit  m_err;
    int  m_gan;
    bit  m_fin;
    int  m_cnt;
    int  edge_n     = 0;
    int  ready_edge = NUNCA;
    int  err_edge   = -1;
    int  wr_edge    = -1;
    int  ev_edge    = -1;
    int  wr_pos;
    int  wr_code;

    int LIN [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic int m_linea();
        for (int l = 0; l < 8; l++) begin
            int a;
            a = cells[LIN[l][0]];
            if (a != 0 && a == cells[LIN[l][1]] && a == cells[LIN[l][2]]) return a;
        end
        return 0;
    endfunction

    function automatic int m_fila(input int r);
        return cells[3*r] + cells[3*r+1] * 4 + cells[3*r+2] * 16;
    endfunction

    // Advance the model by one clock edge with the inputs that edge sampled
    task automatic model_edge(input bit r, input bit j, input bit jg, input int p);
        bit legal;
        edge_n++;
        if (r) begin
            for (int i = 0; i < 9; i++) cells[i] = 0;
            m_turn = 0; m_err = 0; m_gan = 0; m_fin = 0; m_cnt = 0;
            ready_edge = edge_n + 1;
            err_edge = -1; wr_edge = -1; ev_edge = -1;
            return;
        end
        m_err = (edge_n == err_edge);
        if (edge_n == wr_edge) begin
            cells[wr_pos] = wr_code;
            m_turn = !m_turn;
            if (m_cnt < 9) m_cnt++;
        end
        if (edge_n == ev_edge) begin
            int w;
            w = m_linea();
            if (w != 0) begin
                m_gan = w; m_fin = 1;
            end else if (m_cnt == 9) begin
                m_gan = 3; m_fin = 1;
            end else begin
                ready_edge = edge_n + 1;
            end
        end
        if (!m_fin && j && edge_n >= ready_edge) begin
            legal = (p <= 8) && (jg == m_turn);
            if (legal && cells[p] != 0) legal = 0;
            if (legal) begin
                wr_pos = p; wr_code = jg ? 2 : 1;
                wr_edge = edge_n + 2;
                ev_edge = edge_n + 3;
                ready_edge = NUNCA;
            end else begin
                err_edge = edge_n + 1;
                ready_edge = edge_n + 2;
            end
        end
    endtask

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        cmp("fila1", int'(fila1), m_fila(0));
        cmp("fila2", int'(fila2), m_fila(1));
        cmp("fila3", int'(fila3), m_fila(2));
        cmp("turno", int'(turno), int'(m_turn));
        cmp("error", int'(error), int'(m_err));
        cmp("ganador", int'(ganador), m_gan);
        cmp("fin_juego", int'(fin_juego), int'(m_fin));
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic tick(input bit r, input bit j, input bit jg, input int p);
        reset = r; jugada = j; jugador = jg; posicion = 4'(p);
        @(posedge clk);
        model_edge(r, j, jg, p);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0);
    endtask

    task automatic mover(input bit jg, input int p);
        tick(0, 1, jg, p);
        idle(4);
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        idle(1);
    endtask

    initial begin
        reset = 1'b1; jugada = 1'b0; jugador = 1'b0; posicion = 4'd0;
        @(negedge clk);
        do_reset();
        cmp("rst_fila1", int'(fila1), 0);
        cmp("rst_turno", int'(turno), 0);
        cmp("rst_ganador", int'(ganador), 0);
        cmp("rst_fin", int'(fin_juego), 0);

        // X at centre
        mover(0, 4);
        cmp("x4_fila2", int'(fila2), 6'b000100);
        cmp("x4_turno", int'(turno), 1);
        cmp("x4_error", int'(error), 0);

        // X out of turn
        tick(0, 1, 0, 0);
        idle(1);
        cmp("turn_err_pulse", int'(error), 1);
        idle(1);
        cmp("turn_err_end", int'(error), 0);
        cmp("turn_err_fila1", int'(fila1), 0);
        cmp("turn_err_turno", int'(turno), 1);

        // O onto occupied cell, then out of range
        tick(0, 1, 1, 4);
        idle(1);
        cmp("occ_err", int'(error), 1);
        idle(1);
        tick(0, 1, 1, 9);
        idle(1);
        cmp("range_err", int'(error), 1);
        idle(1);
        cmp("range_fila2", int'(fila2), 6'b000100);

        // Strobes while busy are ignored
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 1);
        idle(4);
        cmp("busy_fila1", int'(fila1), 6'b000010);

        // X wins on the top row; later moves ignored
        do_reset();
        mover(0, 0); mover(1, 3); mover(0, 1); mover(1, 4); mover(0, 2);
        cmp("win_fila1", int'(fila1), 6'b010101);
        cmp("win_ganador", int'(ganador), 2'b01);
        cmp("win_fin", int'(fin_juego), 1);
        mover(1, 5);
        cmp("win_ignored", int'(fila2), 6'b001010);

        // Full board, no line
        do_reset();
        mover(0, 0); mover(1, 1); mover(0, 2); mover(1, 4); mover(0, 3);
        mover(1, 5); mover(0, 7); mover(1, 6);
        cmp("pre_draw_fin", int'(fin_juego), 0);
        mover(0, 8);
        cmp("draw_ganador", int'(ganador), 2'b11);
        cmp("draw_fin", int'(fin_juego), 1);

        // Reset during VERIFICA and during ESCRIBE
        do_reset();
        tick(0, 1, 0, 4);
        tick(1, 0, 0, 0);
        idle(3);
        cmp("rst_ver_fila2", int'(fila2), 0);
        cmp("rst_ver_turno", int'(turno), 0);
        tick(0, 1, 0, 4);
        idle(1);
        tick(1, 0, 0, 0);
        idle(3);
        cmp("rst_esc_fila2", int'(fila2), 0);
        cmp("rst_esc_turno", int'(turno), 0);
        mover(0, 4);
        cmp("after_rst_fila2", int'(fila2), 6'b000100);

        // Random play
        for (int n = 0; n < 2000; n++) begin
            bit r, j, jg;
            int p;
            r  = ($urandom % 200 == 0) || (m_fin && $urandom % 8 == 0);
            j  = ($urandom % 3 == 0);
            jg = ($urandom % 4 == 0) ? !m_turn : m_turn;
            p  = ($urandom % 6 == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            tick(r, j, jg, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
